// File: rtl/elevator_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// elevator_ctrl_fsm
//
// Four-floor collective elevator controller. Floor-call buttons are latched
// into a pending-request register; a directional scheduler keeps travelling
// in its current direction while requests remain on that side, stops at any
// pending floor it arrives at, and reverses only from IDLE. Floor travel and
// door-open intervals are measured in clock cycles.
//
// Parameters
//   TRAVEL_CYCLES  clock cycles to move one floor (>= 1)
//   DOOR_CYCLES    clock cycles the door stays open (>= 1)
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high reset
//   req_btn      floor-call buttons, bit n = floor n, level-sampled
//   disp_code    {moving, floor[1:0]} for the 7-segment decoder
//   floor        current floor index 0..3
//   motor_up     high while moving up
//   motor_down   high while moving down
//   door_open    high while the door is open
//   req_pending  latched requests not yet served
// -----------------------------------------------------------------------------
module elevator_ctrl_fsm #(
   parameter int unsigned TRAVEL_CYCLES = 50000000,
   parameter int unsigned DOOR_CYCLES   = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] req_btn,
   output logic [2:0] disp_code,
   output logic [1:0] floor,
   output logic       motor_up,
   output logic       motor_down,
   output logic       door_open,
   output logic [3:0] req_pending
);

   typedef enum logic [1:0] {
      IDLE,
      MOVE_UP,
      MOVE_DOWN,
      DOOR_OPEN
   } state_t;

   localparam logic [31:0] TRAVEL_LAST = TRAVEL_CYCLES - 1;
   localparam logic [31:0] DOOR_LAST   = DOOR_CYCLES - 1;

   state_t      state;
   state_t      state_nx;
   logic        dir;
   logic        dir_nx;
   logic [1:0]  floor_nx;
   logic [31:0] cnt;
   logic [31:0] cnt_nx;
   logic [3:0]  clr;
   logic [3:0]  req_nx;
   logic [3:0]  above_mask;
   logic [3:0]  below_mask;
   logic        above;
   logic        below;
   logic        here;

   // Scheduling decisions look only at latched requests, never at req_btn.
   always_comb begin
      above_mask = '0;
      below_mask = '0;
      case (floor)
         2'd0: begin above_mask = 4'b1110; below_mask = 4'b0000; end
         2'd1: begin above_mask = 4'b1100; below_mask = 4'b0001; end
         2'd2: begin above_mask = 4'b1000; below_mask = 4'b0011; end
         2'd3: begin above_mask = 4'b0000; below_mask = 4'b0111; end
         default: begin above_mask = '0; below_mask = '0; end
      endcase
      above = |(req_pending & above_mask);
      below = |(req_pending & below_mask);
      here  = req_pending[floor];
   end

   always_comb begin
      state_nx = state;
      floor_nx = floor;
      dir_nx   = dir;
      cnt_nx   = cnt;

      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (here) begin
               state_nx = DOOR_OPEN;
            end else if (dir && above) begin
               state_nx = MOVE_UP;
               dir_nx   = 1'b1;
            end else if (dir && below) begin
               state_nx = MOVE_DOWN;
               dir_nx   = 1'b0;
            end else if (!dir && below) begin
               state_nx = MOVE_DOWN;
               dir_nx   = 1'b0;
            end else if (!dir && above) begin
               state_nx = MOVE_UP;
               dir_nx   = 1'b1;
            end
         end

         MOVE_UP: begin
            if (cnt == TRAVEL_LAST) begin
               cnt_nx = '0;
               if (floor == 2'd3) begin
                  // Unreachable by scheduling; keeps floor from wrapping.
                  state_nx = IDLE;
               end else begin
                  floor_nx = floor + 2'd1;
                  if (req_pending[floor_nx]) begin
                     state_nx = DOOR_OPEN;
                  end
               end
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end

         MOVE_DOWN: begin
            if (cnt == TRAVEL_LAST) begin
               cnt_nx = '0;
               if (floor == 2'd0) begin
                  state_nx = IDLE;
               end else begin
                  floor_nx = floor - 2'd1;
                  if (req_pending[floor_nx]) begin
                     state_nx = DOOR_OPEN;
                  end
               end
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end

         DOOR_OPEN: begin
            if (cnt == DOOR_LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 32'd1;
            end
         end

         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase

      // The floor being served is the one the door opens at (the arrival
      // floor on an arrival edge). Clear takes priority over a new press.
      clr = '0;
      if (state_nx == DOOR_OPEN || state == DOOR_OPEN) begin
         clr[floor_nx] = 1'b1;
      end
      req_nx = (req_pending | req_btn) & ~clr;
   end

   // Outputs are registered from the next-state values so they line up
   // exactly with the state register and never see req_btn combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         floor       <= 2'd0;
         dir         <= 1'b1;
         cnt         <= '0;
         req_pending <= '0;
         motor_up    <= 1'b0;
         motor_down  <= 1'b0;
         door_open   <= 1'b0;
         disp_code   <= '0;
      end else begin
         state       <= state_nx;
         floor       <= floor_nx;
         dir         <= dir_nx;
         cnt         <= cnt_nx;
         req_pending <= req_nx;
         motor_up    <= (state_nx == MOVE_UP);
         motor_down  <= (state_nx == MOVE_DOWN);
         door_open   <= (state_nx == DOOR_OPEN);
         disp_code   <= {(state_nx == MOVE_UP) || (state_nx == MOVE_DOWN), floor_nx};
      end
   end

endmodule

// File: tb/tb_elevator_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_elevator_ctrl_fsm
//
// Self-checking bench for elevator_ctrl_fsm with TRAVEL_CYCLES=4 and
// DOOR_CYCLES=3. A behavioural car model (position, motion direction,
// cycles left in the current activity) predicts every output each cycle;
// directed scenarios add literal expectations; a randomized phase drives
// button pulses and occasional resets.
// -----------------------------------------------------------------------------
module tb_elevator_ctrl_fsm;

   localparam int TRAVEL = 4;
   localparam int DOOR   = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] req_btn = '0;
   logic [2:0] disp_code;
   logic [1:0] floor;
   logic       motor_up;
   logic       motor_down;
   logic       door_open;
   logic [3:0] req_pending;

   int n_checks = 0;
   int n_errors = 0;

   elevator_ctrl_fsm #(
      .TRAVEL_CYCLES(TRAVEL),
      .DOOR_CYCLES(DOOR)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_btn(req_btn),
      .disp_code(disp_code),
      .floor(floor),
      .motor_up(motor_up),
      .motor_down(motor_down),
      .door_open(door_open),
      .req_pending(req_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int       m_floor;
   int       m_move;    // +1 up, -1 down, 0 not moving
   bit       m_door;
   bit       m_dir_up;
   int       m_left;    // cycles remaining in travel leg or door interval
   bit [3:0] m_pend;
   bit [3:0] m_serve;
   bit       m_valid = 1'b0;
   bit       want_up;
   bit       want_down;

   always @(posedge clk) begin
      if (reset) begin
         m_floor  = 0;
         m_move   = 0;
         m_door   = 0;
         m_dir_up = 1;
         m_left   = 0;
         m_pend   = '0;
         m_valid  = 1'b1;
      end else if (m_valid) begin
         m_serve = '0;
         if (m_door) begin
            m_serve[m_floor] = 1'b1;
            m_left--;
            if (m_left == 0) m_door = 0;
         end else if (m_move != 0) begin
            m_left--;
            if (m_left == 0) begin
               m_floor += m_move;
               m_left   = TRAVEL;
               if (m_pend[m_floor]) begin
                  m_move = 0;
                  m_door = 1;
                  m_left = DOOR;
                  m_serve[m_floor] = 1'b1;
               end
            end
         end else if (m_pend[m_floor]) begin
            m_door = 1;
            m_left = DOOR;
            m_serve[m_floor] = 1'b1;
         end else begin
            want_up   = 0;
            want_down = 0;
            for (int i = 0; i < 4; i++) begin
               if (m_pend[i] && i > m_floor) want_up = 1;
               if (m_pend[i] && i < m_floor) want_down = 1;
            end
            if ((m_dir_up && want_up) || (!m_dir_up && want_up && !want_down)) begin
               m_move = 1; m_dir_up = 1; m_left = TRAVEL;
            end else if (want_down) begin
               m_move = -1; m_dir_up = 0; m_left = TRAVEL;
            end
         end
         m_pend = (m_pend | req_btn) & ~m_serve;
      end
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("floor", int'(floor), m_floor);
         chk("motor_up", int'(motor_up), int'(m_move == 1));
         chk("motor_down", int'(motor_down), int'(m_move == -1));
         chk("door_open", int'(door_open), int'(m_door));
         chk("req_pending", int'(req_pending), int'(m_pend));
         chk("disp_code", int'(disp_code), (m_move != 0 ? 4 : 0) + m_floor);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus and directed checks ----------------
   initial begin
      int k;
      int door_cnt;

      // 1. reset for two cycles
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_disp", int'(disp_code), 0);
      chk("rst_floor", int'(floor), 0);
      chk("rst_motors", int'({motor_up, motor_down, door_open}), 0);
      chk("rst_pending", int'(req_pending), 0);
      repeat (3) tick();
      chk("idle_disp", int'(disp_code), 0);

      // 2. request at the current floor
      req_btn = 4'b0001;
      tick();
      req_btn = 4'b0000;
      chk("s2_pending", int'(req_pending), 1);
      chk("s2_door_early", int'(door_open), 0);
      door_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (door_open) begin
            door_cnt++;
            chk("s2_pend_clr", int'(req_pending), 0);
         end
         chk("s2_no_motor", int'(motor_up | motor_down), 0);
      end
      chk("s2_door_cycles", door_cnt, 3);

      // 3. request floor 2 from floor 0
      req_btn = 4'b0100;
      tick();
      req_btn = 4'b0000;
      chk("s3_pending", int'(req_pending), 4);
      chk("s3_motor_late", int'(motor_up), 0);
      tick();
      for (int i = 0; i < 8; i++) begin
         chk("s3_motor_up", int'(motor_up), 1);
         chk("s3_disp_move", int'(disp_code), (i < 4) ? 3'b100 : 3'b101);
         tick();
      end
      chk("s3_door", int'(door_open), 1);
      chk("s3_disp_door", int'(disp_code), 3'b010);
      chk("s3_pend_clr", int'(req_pending), 0);

      // 5. hold the served floor's button for the whole door interval
      req_btn = 4'b0100;
      door_cnt = 1;
      for (k = 0; k < 10 && door_open; k++) begin
         tick();
         chk("s5_pend_held", int'(req_pending), 0);
         if (door_open) door_cnt++;
      end
      req_btn = 4'b0000;
      chk("s5_door_cycles", door_cnt, 3);
      tick();
      chk("s5_idle", int'({motor_up, motor_down, door_open}), 0);
      chk("s5_pend", int'(req_pending), 0);

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         reset   = ($urandom_range(0, 599) == 0);
         req_btn = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         tick();
      end
      reset   = 1'b0;
      req_btn = 4'b0000;

      // 6. reset while moving down from floor 3 with 0011 pending
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req_btn = 4'b1000;
      tick();
      req_btn = 4'b0000;
      for (k = 0; k < 200 && !(door_open && floor == 2'd3); k++) tick();
      chk("s6_reach_top", int'(door_open && floor == 2'd3), 1);
      req_btn = 4'b0011;
      tick();
      req_btn = 4'b0000;
      for (k = 0; k < 50 && !motor_down; k++) tick();
      chk("s6_moving_down", int'(motor_down), 1);
      chk("s6_pend_before", int'(req_pending), 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("s6_floor", int'(floor), 0);
      chk("s6_motors", int'({motor_up, motor_down, door_open}), 0);
      chk("s6_pending", int'(req_pending), 0);
      chk("s6_disp", int'(disp_code), 0);
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/elevator_ctrl_fsm.md
# elevator_ctrl_fsm

Four-floor elevator controller. It latches floor-call buttons, runs a directional (collective) scheduling state machine with cycle-counted floor travel and door-open intervals, and drives motor, door and pending-request outputs. It sits directly upstream of the BCD-to-7-segment display decoder and feeds it the 3-bit code `disp_code`.

## Interface
- `TRAVEL_CYCLES`, default 50000000: clock cycles to move one floor; must be ≥1.
- `DOOR_CYCLES`, default 100000000: clock cycles the door stays open; must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_btn`  in  4  floor-call buttons, bit n = floor n; level-sampled every cycle.
- `disp_code`  out  3  display code to the 7-seg decoder: `{moving, floor[1:0]}`.
- `floor`  out  2  current floor index, 0..3.
- `motor_up`  out  1  high while in MOVE_UP.
- `motor_down`  out  1  high while in MOVE_DOWN.
- `door_open`  out  1  high while in DOOR_OPEN.
- `req_pending`  out  4  latched, not-yet-served requests.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN.
- Registers:
  - `state`
  - `floor` (2 b)
  - `dir` (1 = up)
  - `req_pending` (4 b)
  - `cnt` (32 b)
- All outputs are decoded from these registers only. No combinational path from `req_btn` reaches any output.
- Request latch: each edge, `req_pending <= (req_pending | req_btn) & ~clr`.
  - `clr` has bit `floor` set whenever the next state is DOOR_OPEN, or the current state is DOOR_OPEN.
  - Clear wins over set. A button held at the served floor is therefore ignored.
- Decision terms, evaluated on `req_pending` only:
  - `above` = any pending bit greater than `floor`.
  - `below` = any pending bit less than `floor`.
  - `here` = `req_pending[floor]`.
- IDLE transitions, in priority order:
  1. `here` → DOOR_OPEN.
  2. `dir`=1 and `above` → MOVE_UP.
  3. `dir`=1 and `below` → MOVE_DOWN, with `dir`<=0.
  4. `dir`=0 and `below` → MOVE_DOWN.
  5. `dir`=0 and `above` → MOVE_UP, with `dir`<=1.
  6. Otherwise stay in IDLE.
  - Entering MOVE_UP always sets `dir`=1; entering MOVE_DOWN always sets `dir`=0.
- MOVE_UP:
  - `cnt` increments each cycle.
  - At `cnt`==`TRAVEL_CYCLES`-1: `floor`<=`floor`+1 and `cnt`<=0.
  - Then, if the request for the new floor is pending → DOOR_OPEN; else stay in MOVE_UP.
  - MOVE_DOWN is symmetric, with `floor`-1.
  - Scheduling never enters MOVE_UP at floor 3 or MOVE_DOWN at floor 0. `floor` never wraps.
- DOOR_OPEN:
  - `cnt` increments each cycle.
  - At `cnt`==`DOOR_CYCLES`-1: `cnt`<=0 → IDLE.
  - Presses at the current floor do not extend the door time.
- `disp_code` = `{state==MOVE_UP || state==MOVE_DOWN, floor}`.
  - Codes 000..011: stopped at floors 0..3.
  - Codes 100..111: moving, last floor passed.

## Timing
- Reset values: `state`=IDLE, `floor`=0, `dir`=1, `cnt`=0, `req_pending`=0000, `disp_code`=000. `motor_up`, `motor_down` and `door_open` are all 0.
- Reset mid-operation discards pending requests and position. The block restarts at floor 0 with no motion.
- Request latency: a button sampled at edge E is visible in `req_pending` after E. The state reacts at edge E+1, so motor or door outputs assert one cycle after `req_pending`.
- Travel: exactly `TRAVEL_CYCLES` cycles per floor. `floor` updates on the last cycle's edge, together with any DOOR_OPEN entry.
- Door interval: exactly `DOOR_CYCLES` cycles. IDLE lasts at least 1 cycle between door close and the next action.
- A request for a floor that is passed mid-travel is served when the car arrives at it, if it is pending at that arrival edge.

## Test plan
Parameters for all scenarios: `TRAVEL_CYCLES`=4, `DOOR_CYCLES`=3.
1. Assert `reset` for 2 cycles, release → all outputs at reset values; `disp_code`=000 held with no requests.
2. At floor 0 IDLE, pulse `req_btn`=0001 for one cycle → `req_pending`=0001 for one cycle, then `door_open`=1 for exactly 3 cycles with `req_pending`=0000; no motor activity.
3. At floor 0, pulse 0100 → `motor_up` asserts two edges after the press and stays high 8 cycles. `disp_code` goes 100, then 101, then `door_open` with `disp_code`=010; `req_pending` clears.
4. Request 1000 from floor 0. While moving up between floors 1 and 2, pulse 0101 → stops at 2 (door), continues to 3 (door), then moves down to 0 (door). `dir` flips only at the IDLE at floor 3.
5. During DOOR_OPEN at floor 2, hold `req_btn`=0100 for the whole interval → door closes after 3 cycles, `req_pending` stays 0000, controller goes IDLE.
6. Assert `reset` one cycle while MOVE_DOWN from floor 3 with `req_pending`=0011 → next cycle `floor`=0, IDLE, `req_pending`=0000, motors 0.
